// File: rtl/vec_writeback_pkg.sv
// Shared widths, entry layout and helpers for the vector write-back path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package vec_writeback_pkg;

    localparam int LANES      = 8;
    localparam int DW         = 32;
    localparam int VRW        = 5;
    localparam int LANE_W     = 3;
    localparam int ADDR_W     = VRW + LANE_W;
    localparam int ENTRY_W    = VRW + LANES + LANES * DW;

    // One buffered ALU result: destination register, lane enables, lane data
    typedef struct packed {
        logic [VRW-1:0]      vd;
        logic [LANES-1:0]    mask;
        logic [LANES*DW-1:0] data;
    } vwb_entry_t;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_DRAIN = 1'b1
    } wb_state_t;

    // Vector funct codes already issued by the execute stage
    typedef enum logic [3:0] {
        VF_ADD = 4'h0,
        VF_SUB = 4'h1,
        VF_AND = 4'h2,
        VF_OR  = 4'h3,
        VF_XOR = 4'h4,
        VF_SLL = 4'h5,
        VF_SRL = 4'h6,
        VF_MUL = 4'h7
    } vfunct_t;

    // Register-file lane address: vector register index above lane index
    function automatic logic [ADDR_W-1:0] lane_addr(input logic [VRW-1:0]    vd,
                                                    input logic [LANE_W-1:0] lane);
        return {vd, lane};
    endfunction

    // Lane i lives at [DW*i +: DW] of the packed vector
    function automatic logic [DW-1:0] lane_data(input logic [LANES*DW-1:0] data,
                                                input logic [LANE_W-1:0]   lane);
        return data[lane * DW +: DW];
    endfunction

endpackage

// File: rtl/vwb_fifo.sv
// Two-entry synchronous FIFO, head-first, holding write-back entries.
// Latency: pushed entry is visible at head the cycle after the push edge.
// Backpressure: caller must not push when count == 2 nor pop when empty.
module vwb_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // Storage needs no reset: count gates whether head is meaningful
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; push+pop together leaves count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/vec_writeback.sv
// Buffers up to two 8-lane vector results and drains them one lane per cycle to the VRF write port.
// Latency: first write the cycle after the accepting edge; done one cycle after the lane-7 advance.
// Backpressure: in_ready low while two entries are held; wr_stall holds the current lane in place.
module vec_writeback
    import vec_writeback_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VRW-1:0]       in_vd,
    input  logic [LANES-1:0]     in_mask,
    input  logic [LANES*DW-1:0]  in_data,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DW-1:0]        wr_data,
    input  logic                 wr_stall,
    output logic                 done,
    output logic [VRW-1:0]       done_vd,
    output logic                 busy
);

    vwb_entry_t         push_entry;
    vwb_entry_t         head;
    logic [ENTRY_W-1:0] head_bits;
    logic [1:0]         count;
    wb_state_t          state;
    logic [LANE_W-1:0]  lane;
    logic               rdy_q;
    logic               push;
    logic               pop;
    logic               advance;
    logic               lane_on;
    logic               mask_zero;
    logic               last_lane;
    logic               stay_busy;

    assign push_entry = '{vd: in_vd, mask: in_mask, data: in_data};

    vwb_fifo #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .head     (head_bits),
        .count    (count)
    );

    assign head = vwb_entry_t'(head_bits);

    // Accept path: gated by a flop so in_ready stays low throughout reset
    assign in_ready = rdy_q & (count != 2'd2);
    assign push     = in_valid & in_ready;

    // Lane stepping: masked-off lanes take one silent cycle and ignore the stall;
    // an all-zero mask retires the whole entry in one cycle
    assign lane_on   = head.mask[lane];
    assign mask_zero = (head.mask == '0);
    assign advance   = (state == WB_DRAIN) & (mask_zero | ~lane_on | ~wr_stall);
    assign last_lane = mask_zero | (lane == LANE_W'(LANES - 1));
    assign pop       = advance & last_lane;

    // FIFO still holds something after this edge
    assign stay_busy = push | (count == 2'd2) | ((count == 2'd1) & ~pop);

    // Write port decode from state, lane counter and FIFO head only
    assign wr_en   = (state == WB_DRAIN) & lane_on;
    assign wr_addr = wr_en ? lane_addr(head.vd, lane) : '0;
    assign wr_data = wr_en ? lane_data(head.data, lane) : '0;
    assign busy    = (count != 2'd0);

    // Drain sequencer: state, lane counter and the registered retire pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WB_IDLE;
            lane    <= '0;
            done    <= 1'b0;
            done_vd <= '0;
        end else begin
            done <= pop;
            if (pop) begin
                done_vd <= head.vd;
            end
            case (state)
                WB_IDLE: begin
                    lane <= '0;
                    if (stay_busy) begin
                        state <= WB_DRAIN;
                    end
                end
                WB_DRAIN: begin
                    if (pop) begin
                        lane <= '0;
                    end else if (advance) begin
                        lane <= lane + 3'd1;
                    end
                    if (!stay_busy) begin
                        state <= WB_IDLE;
                    end
                end
                default: begin
                    state <= WB_IDLE;
                    lane  <= '0;
                end
            endcase
        end
    end

    // Ready enable rises on the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vec_writeback.sv
// Scoreboard bench for vec_writeback: expected lane writes and retirements queued at accept.
// Latency: checks first-write, drain, stall and retire cycle offsets against the accept cycle.
// Backpressure: exercises in_ready deassertion with three back-to-back pushes and wr_stall.
module tb_vec_writeback;
    import vec_writeback_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [VRW-1:0]      in_vd;
    logic [LANES-1:0]    in_mask;
    logic [LANES*DW-1:0] in_data;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DW-1:0]       wr_data;
    logic                wr_stall;
    logic                done;
    logic [VRW-1:0]      done_vd;
    logic                busy;

    always #5 clk = ~clk;

    vec_writeback dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vd    (in_vd),
        .in_mask  (in_mask),
        .in_data  (in_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_stall (wr_stall),
        .done     (done),
        .done_vd  (done_vd),
        .busy     (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    int cyc        = 0;
    int wr_count   = 0;
    int done_count = 0;
    int acc_count  = 0;
    int wr_log   [128];
    int done_log [128];
    int acc_log  [128];

    logic [ADDR_W+DW-1:0] exp_wr_q   [$];
    logic [VRW-1:0]       exp_done_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: log accepts, compare completed writes and retirements against the queues
    always @(negedge clk) begin
        logic [ADDR_W+DW-1:0] e;
        logic [VRW-1:0]       v;
        cyc = cyc + 1;
        if (!rst_n) begin
            exp_wr_q.delete();
            exp_done_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                for (int i = 0; i < LANES; i++) begin
                    if (in_mask[i]) begin
                        exp_wr_q.push_back({in_vd, 3'(i), in_data[DW*i +: DW]});
                    end
                end
                exp_done_q.push_back(in_vd);
                acc_log[acc_count % 128] = cyc;
                acc_count++;
            end
            if (wr_en && !wr_stall) begin
                chk("wr_expected", 64'(exp_wr_q.size() > 0), 64'd1);
                if (exp_wr_q.size() > 0) begin
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e[ADDR_W+DW-1:DW]));
                    chk("wr_data", 64'(wr_data), 64'(e[DW-1:0]));
                end
                wr_log[wr_count % 128] = cyc;
                wr_count++;
            end
            if (!wr_en) begin
                chk("idle_zero", 64'({wr_addr, wr_data}), 64'd0);
            end
            if (done) begin
                chk("done_expected", 64'(exp_done_q.size() > 0), 64'd1);
                if (exp_done_q.size() > 0) begin
                    v = exp_done_q.pop_front();
                    chk("done_vd", 64'(done_vd), 64'(v));
                end
                done_log[done_count % 128] = cyc;
                done_count++;
            end
        end
    end

    // Present one vector from just after a rising edge until it is accepted
    task automatic push_vec(input logic [VRW-1:0] vd, input logic [LANES-1:0] mask,
                            input logic [DW-1:0] base);
        int t = 0;
        in_valid = 1'b1;
        in_vd    = vd;
        in_mask  = mask;
        for (int i = 0; i < LANES; i++) begin
            in_data[DW*i +: DW] = base + 32'(i);
        end
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("push_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until the FIFO drains and every queued retirement is seen
    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((busy || exp_done_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", 64'(t < 200), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t, required finish before it", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int w0;
        int d0;
        int a0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_vd    = '0;
        in_mask  = '0;
        in_data  = '0;
        wr_stall = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wr_en",    64'(wr_en),    64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_done",     64'(done),     64'd0);
        chk("rst_done_vd",  64'(done_vd),  64'd0);
        chk("rst_wr_addr",  64'(wr_addr),  64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single vector, full mask
        w0 = wr_count; d0 = done_count; a0 = acc_count;
        push_vec(5'd3, 8'hFF, 32'h100);
        wait_idle();
        a = acc_log[a0];
        chk("t1_writes",   64'(wr_count - w0),   64'd8);
        chk("t1_first",    64'(wr_log[w0]),      64'(a + 1));
        chk("t1_last",     64'(wr_log[w0 + 7]),  64'(a + 8));
        chk("t1_done_cnt", 64'(done_count - d0), 64'd1);
        chk("t1_done_cyc", 64'(done_log[d0]),    64'(a + 9));

        // Sparse mask: lanes 0, 5, 7
        w0 = wr_count; d0 = done_count; a0 = acc_count;
        push_vec(5'd5, 8'b1010_0001, 32'h200);
        wait_idle();
        a = acc_log[a0];
        chk("t2_writes",   64'(wr_count - w0),   64'd3);
        chk("t2_first",    64'(wr_log[w0]),      64'(a + 1));
        chk("t2_last",     64'(wr_log[w0 + 2]),  64'(a + 8));
        chk("t2_done_cnt", 64'(done_count - d0), 64'd1);
        chk("t2_done_cyc", 64'(done_log[d0]),    64'(a + 9));

        // Backpressure: three vectors back to back
        w0 = wr_count; d0 = done_count; a0 = acc_count;
        push_vec(5'd10, 8'hFF, 32'h1000);
        push_vec(5'd11, 8'hFF, 32'h1100);
        @(negedge clk);
        chk("t3_rdy_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        push_vec(5'd13, 8'hFF, 32'h1300);
        wait_idle();
        a = acc_log[a0];
        chk("t3_writes",   64'(wr_count - w0),                64'd24);
        chk("t3_nobubble", 64'(wr_log[w0 + 23] - wr_log[w0]), 64'd23);
        chk("t3_acc2",     64'(acc_log[a0 + 1]),              64'(a + 1));
        chk("t3_acc3",     64'(acc_log[a0 + 2]),              64'(a + 9));
        chk("t3_done_cnt", 64'(done_count - d0),              64'd3);
        chk("t3_done_cyc", 64'(done_log[d0 + 2]),             64'(a + 25));

        // Stall three cycles on lane 2
        w0 = wr_count; d0 = done_count; a0 = acc_count;
        push_vec(5'd7, 8'hFF, 32'h400);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        wr_stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall_en",   64'(wr_en),   64'd1);
            chk("t4_stall_addr", 64'(wr_addr), 64'h3A);
            chk("t4_stall_data", 64'(wr_data), 64'h402);
            @(posedge clk);
            #1;
        end
        wr_stall = 1'b0;
        wait_idle();
        a = acc_log[a0];
        chk("t4_writes",   64'(wr_count - w0),   64'd8);
        chk("t4_last",     64'(wr_log[w0 + 7]),  64'(a + 11));
        chk("t4_done_cyc", 64'(done_log[d0]),    64'(a + 12));

        // mask == 0
        w0 = wr_count; d0 = done_count; a0 = acc_count;
        push_vec(5'd9, 8'h00, 32'h500);
        wait_idle();
        a = acc_log[a0];
        chk("t5_writes",   64'(wr_count - w0),   64'd0);
        chk("t5_done_cnt", 64'(done_count - d0), 64'd1);
        chk("t5_done_cyc", 64'(done_log[d0]),    64'(a + 2));

        // Reset after lane 4
        w0 = wr_count; d0 = done_count;
        push_vec(5'd20, 8'hFF, 32'h600);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_wr_en",    64'(wr_en),    64'd0);
        chk("t6_busy",     64'(busy),     64'd0);
        chk("t6_rdy_rst",  64'(in_ready), 64'd0);
        chk("t6_done",     64'(done),     64'd0);
        chk("t6_done_vd",  64'(done_vd),  64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_rdy_after", 64'(in_ready),          64'd1);
        chk("t6_busy_after", 64'(busy),             64'd0);
        chk("t6_writes",    64'(wr_count - w0),     64'd5);
        chk("t6_no_done",   64'(done_count - d0),   64'd0);
        chk("t6_flushed",   64'(exp_wr_q.size()),   64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vec_writeback.md
# vec_writeback

Vector result write-back serializer for the vector datapath. It accepts one 8-lane, 32-bit ALU result per handshake, together with the destination vector register index and a lane mask. It buffers up to two results and drains them lane by lane into the single 32-bit write port of the vector register file. It sits between the execute-stage vector ALU outputs and the vector register file, and is the write side matching the register-file read lanes that feed the ALU.

## Interface
- LANES, 8, lanes per vector (fixed; lane index is 3 bits)
- DW, 32, lane data width
- VRW, 5, destination vector register index width
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  result present on in_* this cycle
- in_ready  output  1  block can accept a result; 0 while rst_n low
- in_vd  input  VRW  destination vector register index
- in_mask  input  LANES  bit i = 1 → lane i is written
- in_data  input  LANES*DW  lane i at [DW*i+DW-1 : DW*i]
- wr_en  output  1  register-file write strobe
- wr_addr  output  VRW+3  {vd, lane}
- wr_data  output  DW  lane data
- wr_stall  input  1  register-file port busy; write not taken
- done  output  1  one-cycle pulse, one vector retired
- done_vd  output  VRW  vd of the retired vector, valid with done
- busy  output  1  FIFO non-empty

## Operation
- **Accept.** An entry {vd, mask, data} is pushed when in_valid & in_ready. in_ready = (count < 2), decoded from the registered count.
- **FIFO.** 2-entry FIFO, head first. When full, in_ready = 0, so no push occurs on a pop cycle (no pass-through).
- **FSM: IDLE.** count == 0. wr_en = 0, lane = 0.
- **FSM: IDLE → DRAIN.** Taken when count > 0.
- **FSM: DRAIN.** lane counter 0..7 on the head entry.
- **Masked-on lane.** wr_en = 1, wr_addr = {head.vd, lane}, wr_data = head.data[lane].
- **Advance rule.** The lane advances when a write completes (wr_en & ~wr_stall), or unconditionally for a masked-off lane (wr_en = 0, one cycle, wr_stall ignored).
- **Stall.** While a masked-on lane is stalled, wr_en, wr_addr and wr_data hold constant.
- **Retire.** On lane 7 advancing: pop the head, lane ← 0, and the next cycle assert done with done_vd = retired vd. Go to IDLE if the FIFO is now empty, otherwise continue in DRAIN with the next entry.
- **mask == 0.** The entry retires in a single cycle with no writes, then done is pulsed.
- **Outputs when idle.** wr_addr and wr_data are 0 whenever wr_en = 0.
- **Arithmetic.** No arithmetic on data; lane data passes through unchanged.
- **Reset values.** in_ready 0 during reset and 1 after; wr_en 0; wr_addr 0; wr_data 0; done 0; done_vd 0; busy 0; count 0; lane 0; state IDLE.
- **Reset mid-drain.** Buffered entries are discarded; no further writes; no done pulse.

## Timing
- All outputs are decoded from registers only; there is no combinational path from in_* or wr_stall to any output except through state.
- **First write.** Push at edge N → first possible wr_en in the cycle after N.
- **Drain time.** Full mask, no stall: 8 consecutive write cycles. done is high in the cycle after the lane-7 write.
- **Back-to-back entries.** Lane 0 of the second entry is written in the cycle immediately after lane 7 of the first (no bubble).
- **Throughput.** Sustained 1 vector per 8 cycles. in_ready falls when the second entry is held while the first is still draining.
- **Push and pop in one edge with count == 1.** count stays 1, the new entry becomes head, lane = 0.
- **Stall.** Each stalled cycle adds exactly one cycle of latency.

## Structure
- **Shared header vec_defs.vh.**
  - LANES, DW, VRW.
  - Lane-address concatenation macro.
  - Entry field widths (VRW + LANES + LANES*DW).
  - Vector funct codes already used by the execute stage.
- **Sub-module vwb_fifo.** 2-entry synchronous FIFO with push, pop, head, count, async active-low reset.
- **Top.** FSM, lane counter and output decode live in vec_writeback.

## Test plan
- **Single vector, full mask.** Push vd=3, mask=8'hFF, lane i = 32'h100+i. Required: wr_addr 8'h18..8'h1F on 8 consecutive cycles with data 32'h100..32'h107; then done=1 with done_vd=3.
- **Sparse mask.** Push mask=8'b1010_0001. Required: writes only to lanes 0, 5 and 7, 8 cycles total, done once.
- **Backpressure.** Push 3 vectors back-to-back. Required: in_ready=0 after the 2nd push until the 1st retires; 24 writes with no bubble; done_vd order preserved.
- **Stall.** Hold wr_stall=1 for 3 cycles on lane 2. Required: wr_addr and wr_data constant during the stall; total 11 cycles; no lane skipped or duplicated.
- **mask == 0.** Required: no wr_en, done pulse 2 cycles after the push.
- **Reset mid-drain.** Assert rst_n=0 after lane 4. Required: wr_en=0 immediately, no done, busy=0, in_ready=1 after release.
